// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  mem_port_arbiter
//  Shares one single-ported memory between instruction fetch and data access,
//  one outstanding transaction, data priority with a fetch starvation guard.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,

  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,

  input  logic                flush,

  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int         BE_W       = DATA_W / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_owner_d;
  logic       r_we;
  logic       r_drop;
  logic [3:0] r_starve_cnt;

  logic       w_gnt_if;
  logic       w_gnt_d;
  logic       w_if_forced;
  logic       w_ack;
  logic       w_if_resp;
  logic       w_d_resp;

  assign w_if_forced = (r_starve_cnt >= STARVE_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grants are gated by rst so nothing leaks onto the memory bus during reset.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_if    = 1'b0;
    w_gnt_d     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!rst) begin
          if (d_req && !(if_req && w_if_forced)) begin
            w_gnt_d = 1'b1;
          end else if (if_req) begin
            w_gnt_if = 1'b1;
          end
          if (d_req || if_req) begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign if_gnt  = w_gnt_if;
  assign d_gnt   = w_gnt_d;
  assign mem_req = w_gnt_if | w_gnt_d;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (w_gnt_d) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end else if (w_gnt_if) begin
      mem_addr  = if_addr;
      mem_be    = {BE_W{1'b1}};
    end
  end

  // Owner/we/drop describe the single transaction currently in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_drop    <= 1'b0;
    end else if (w_gnt_if || w_gnt_d) begin
      r_owner_d <= w_gnt_d;
      r_we      <= w_gnt_d & d_we;
      r_drop    <= 1'b0;
    end else if ((r_state == ST_WAIT) && !r_owner_d && flush) begin
      r_drop    <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if (w_gnt_if) begin
      r_starve_cnt <= 4'd0;
    end else if (w_gnt_d && if_req) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // An ack seen in IDLE (e.g. left over from before a reset) is ignored.
  assign w_ack     = (r_state == ST_WAIT) && mem_rvalid;
  assign w_if_resp = w_ack && !r_owner_d && !r_drop && !flush;
  assign w_d_resp  = w_ack && r_owner_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= w_if_resp;
      d_rvalid  <= w_d_resp;
      if (w_if_resp) begin
        if_rdata <= mem_rdata;
      end
      if (w_d_resp) begin
        d_rdata <= r_we ? '0 : mem_rdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  tb_mem_port_arbiter
//  Directed scenarios plus random traffic against a transaction-level model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int BE_W       = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req, d_we, d_gnt, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic [BE_W-1:0]   d_be;
  logic              flush;
  logic              mem_req, mem_we, mem_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [BE_W-1:0]   mem_be;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Stimulus for the next cycle
  bit          s_rst, s_if_req, s_d_req, s_d_we, s_flush, s_force_rv, s_hold, s_spurious_ok;
  logic [31:0] s_if_addr, s_d_addr, s_d_wdata, s_rdata;
  logic [3:0]  s_d_be;
  int          s_lat;

  // Transaction-level reference model
  bit          m_busy, m_owner_d, m_we, m_drop;
  int          m_starve, m_lat;
  bit          e_if_rv, e_d_rv;
  logic [31:0] e_if_rd, e_d_rd;
  bit          g_if, g_d;

  task automatic model_reset();
    m_busy = 0; m_owner_d = 0; m_we = 0; m_drop = 0; m_starve = 0; m_lat = 0;
    e_if_rv = 0; e_d_rv = 0; e_if_rd = '0; e_d_rd = '0;
  endtask

  task automatic step();
    bit rv, exp_gif, exp_gd, ewe;
    logic [31:0] ea, ewd;
    logic [3:0]  ebe;
    @(negedge clk);
    rv = s_force_rv;
    if (m_busy && m_lat > 0) begin
      m_lat--;
      if (m_lat == 0) rv = 1;
    end else if (!m_busy && s_spurious_ok && $urandom_range(0, 9) == 0) begin
      rv = 1;
    end
    rst = s_rst; flush = s_flush; mem_rvalid = rv; mem_rdata = s_rdata;
    if_req = s_if_req; if_addr = s_if_addr;
    d_req = s_d_req; d_we = s_d_we; d_addr = s_d_addr; d_wdata = s_d_wdata; d_be = s_d_be;
    if (s_rst) model_reset();
    #1;
    exp_gd  = !s_rst && !m_busy && s_d_req && !(s_if_req && m_starve >= STARVE_MAX);
    exp_gif = !s_rst && !m_busy && s_if_req && !exp_gd;
    ewe = 0; ea = '0; ewd = '0; ebe = '0;
    if (exp_gd) begin
      ewe = s_d_we; ea = s_d_addr; ewd = s_d_wdata; ebe = s_d_be;
    end else if (exp_gif) begin
      ea = s_if_addr; ebe = 4'hF;
    end
    check_value("gnt", {if_gnt, d_gnt}, {exp_gif, exp_gd});
    check_value("mem_bus", {mem_req, mem_we, mem_be, mem_addr, mem_wdata},
                {exp_gif | exp_gd, ewe, ebe, ea, ewd});
    check_value("if_resp", {if_rvalid, if_rdata}, {e_if_rv, e_if_rd});
    check_value("d_resp", {d_rvalid, d_rdata}, {e_d_rv, e_d_rd});
    // Advance the model across the coming rising edge
    if (!s_rst) begin
      e_if_rv = 0; e_d_rv = 0;
      if (m_busy && rv) begin
        e_if_rv = !m_owner_d && !m_drop && !s_flush;
        if (e_if_rv) e_if_rd = s_rdata;
        e_d_rv = m_owner_d;
        if (m_owner_d) e_d_rd = m_we ? 32'h0 : s_rdata;
        m_busy = 0;
      end else if (m_busy && !m_owner_d && s_flush) begin
        m_drop = 1;
      end
      if (exp_gd || exp_gif) begin
        m_busy = 1; m_owner_d = exp_gd; m_we = exp_gd && s_d_we; m_drop = 0; m_lat = s_lat;
        if (exp_gif) m_starve = 0;
        else if (s_if_req) m_starve++;
      end
    end
    g_if = exp_gif; g_d = exp_gd;
    if (!s_hold) begin
      if (exp_gif) s_if_req = 0;
      if (exp_gd)  s_d_req  = 0;
    end
  endtask

  task automatic do_reset();
    s_if_req = 0; s_d_req = 0; s_flush = 0; s_force_rv = 0; s_hold = 0;
    s_rst = 1; step();
    s_rst = 0;
  endtask

  initial begin
    logic [9:0] order;
    int         n_grants;
    rst = 1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_be = '0; flush = 0; mem_rvalid = 0; mem_rdata = '0;
    s_rst = 0; s_if_req = 0; s_d_req = 0; s_d_we = 0; s_flush = 0; s_force_rv = 0;
    s_hold = 0; s_spurious_ok = 0; s_if_addr = '0; s_d_addr = '0; s_d_wdata = '0;
    s_rdata = '0; s_d_be = '0; s_lat = 1;
    model_reset();

    // Reset state, with a stray ack and a request present
    s_rst = 1; s_if_req = 1; s_force_rv = 1; step();
    check_value("rst_outputs", {if_gnt, d_gnt, mem_req, if_rvalid, d_rvalid, if_rdata, d_rdata}, '0);
    do_reset();

    // IF alone, latency 2, request held to observe the next grant slot
    s_hold = 1; s_if_req = 1; s_if_addr = 32'h100; s_lat = 2; s_rdata = 32'h0050_0093;
    step(); check_value("t1_gnt_c0", {if_gnt, mem_req, mem_addr}, {2'b11, 32'h100});
    step(); check_value("t1_gnt_c1", if_gnt, 1'b0);
    step(); check_value("t1_gnt_c2", if_gnt, 1'b0);
    step(); check_value("t1_resp_c3", {if_rvalid, if_rdata}, {1'b1, 32'h0050_0093});
    check_value("t1_regrant_c3", if_gnt, 1'b1);
    s_hold = 0; s_if_req = 0;
    step(); step(); step();

    // Store
    s_d_req = 1; s_d_we = 1; s_d_addr = 32'h2000; s_d_wdata = 32'hDEAD_BEEF; s_d_be = 4'b0011;
    s_lat = 1; s_rdata = 32'h5555_AAAA;
    step(); check_value("t2_store_bus", {mem_we, mem_be, mem_wdata}, {1'b1, 4'b0011, 32'hDEAD_BEEF});
    step();
    step(); check_value("t2_store_resp", {d_rvalid, d_rdata, if_rvalid}, {1'b1, 32'h0, 1'b0});

    // Starvation guard with both requests held
    do_reset();
    s_hold = 1; s_if_req = 1; s_if_addr = 32'h300; s_d_req = 1; s_d_we = 0; s_d_addr = 32'h4000;
    s_lat = 1; order = '0; n_grants = 0;
    for (int i = 0; i < 60 && n_grants < 10; i++) begin
      step();
      if (g_if || g_d) begin
        order = {order[8:0], g_if};
        n_grants++;
      end
    end
    check_value("t3_grant_order", order, 10'b00001_00001);
    do_reset();

    // Flush one cycle after an IF grant
    s_if_req = 1; s_if_addr = 32'h100; s_lat = 3; s_rdata = 32'h0BAD_0BAD;
    step(); s_flush = 1; step(); s_flush = 0; step(); step(); step();
    check_value("t4_dropped", if_rvalid, 1'b0);
    s_if_req = 1; s_if_addr = 32'h200; s_lat = 1; s_rdata = 32'h1234_5678;
    step(); step();
    step(); check_value("t4_refetch", {if_rvalid, if_rdata}, {1'b1, 32'h1234_5678});

    // Flush coincident with the ack, then flush during a D load
    s_if_req = 1; s_if_addr = 32'h204; s_lat = 2;
    step(); step(); s_flush = 1; step(); s_flush = 0;
    step(); check_value("t5_if_flush_ack", if_rvalid, 1'b0);
    s_d_req = 1; s_d_we = 0; s_d_addr = 32'h3000; s_lat = 2; s_rdata = 32'hCAFE_F00D;
    step(); s_flush = 1; step(); step(); s_flush = 0;
    step(); check_value("t5_d_flush", {d_rvalid, d_rdata}, {1'b1, 32'hCAFE_F00D});

    // Reset mid-WAIT, then a late ack
    s_d_req = 1; s_d_we = 0; s_d_addr = 32'h3004; s_lat = 3;
    step();
    s_rst = 1; s_if_req = 1; s_if_addr = 32'h400;
    step(); check_value("t6_in_reset", {if_gnt, d_gnt, mem_req, if_rvalid, d_rvalid, d_rdata}, '0);
    s_rst = 0; s_force_rv = 1; s_lat = 2;
    step(); check_value("t6_first_grant", {if_gnt, mem_req}, 2'b11);
    s_force_rv = 0;
    step(); check_value("t6_no_pulse", {if_rvalid, d_rvalid}, 2'b00);
    step(); step(); step();

    // Random traffic
    s_spurious_ok = 1;
    for (int i = 0; i < 1500; i++) begin
      if (s_if_req) begin
        if ($urandom_range(0, 15) == 0) s_if_req = 0;
      end else if ($urandom_range(0, 1) == 1) begin
        s_if_req = 1; s_if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (s_d_req) begin
        if ($urandom_range(0, 15) == 0) s_d_req = 0;
      end else if ($urandom_range(0, 1) == 1) begin
        s_d_req = 1; s_d_we = 1'($urandom_range(0, 1)); s_d_addr = $urandom;
        s_d_wdata = $urandom; s_d_be = 4'($urandom_range(0, 15));
      end
      s_flush = ($urandom_range(0, 4) == 0);
      s_lat   = $urandom_range(1, 3);
      s_rdata = $urandom;
      s_rst   = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch (IF) stage and the data (MEM) stage of the pipelined core.
- Allows one outstanding transaction at a time, with a req/gnt/rvalid handshake on each side.
- Data port has fixed priority, with a starvation guard for fetch.
- Flush input discards a stale fetch response after a taken branch or jump.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte-enable width is DATA_W/8)
STARVE_MAX, 4, consecutive lost IF contests before IF is forced to win (range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  one-cycle pulse, fetch data valid
if_rdata  out  DATA_W  fetch data
d_req  in  1  data request; held with d_* fields until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_be  in  DATA_W/8  byte enables
d_gnt  out  1  data accepted this cycle
d_rvalid  out  1  one-cycle pulse, load data valid or store complete
d_rdata  out  DATA_W  load data (0 for stores)
flush  in  1  discard any outstanding fetch response
mem_req  out  1  one-cycle issue strobe to memory
mem_we  out  1  write enable
mem_addr  out  ADDR_W  address
mem_wdata  out  DATA_W  write data
mem_be  out  DATA_W/8  byte enables
mem_rvalid  in  1  memory response/ack, one cycle, any latency ≥1 after mem_req
mem_rdata  in  DATA_W  read data, valid with mem_rvalid

Behaviour:

State machine: IDLE, WAIT.
- IDLE: a grant occurs if either request is high. Go to WAIT and record the owner (IF or D), the we bit, and drop=0.
- WAIT: no grants. On mem_rvalid, go to IDLE. A new grant is possible at the earliest the following cycle, so maximum throughput is one transaction per latency+1 cycles.

Arbitration (IDLE only):
- Only d_req: D wins.
- Only if_req: IF wins.
- Both requests:
  - D wins if starve_cnt < STARVE_MAX; starve_cnt then increments.
  - Otherwise IF wins.
- starve_cnt clears whenever IF is granted. It holds when IF is not requesting.

Grant cycle (combinational from state and requests):
- The winner's gnt=1, mem_req=1.
- mem_we, mem_addr, mem_wdata, mem_be are driven from the winner's fields.
- An IF grant drives mem_we=0, mem_be all ones, mem_wdata=0.
- Outside a grant, mem_req=0 and all mem_* outputs are 0.

Response (registered, one cycle after mem_rvalid):
- Owner IF with drop=0: if_rvalid=1, if_rdata=mem_rdata.
- Owner D: d_rvalid=1. d_rdata=mem_rdata for loads, 0 for stores.
- rdata outputs hold their last value when rvalid=0.

Flush:
- flush in WAIT with owner IF sets drop=1. The response is consumed from memory but no if_rvalid is produced.
- flush in the same cycle as mem_rvalid also suppresses the response.
- flush in a grant cycle does not drop the newly granted fetch.
- flush has no effect on D transactions or in IDLE.

Boundary rules:
- mem_rvalid while in IDLE is ignored, with no output pulse (for example, a late ack after reset).
- A request deasserted before gnt is simply not serviced. No state is kept.

Reset (asynchronous):
- State to IDLE; starve_cnt, owner and drop to 0.
- if_rvalid, d_rvalid, if_rdata and d_rdata to 0.
- All grants and mem_* outputs are 0 while rst=1.
- Reset mid-WAIT abandons the transaction; its later mem_rvalid is ignored.

Test Plan:
1. IF alone: if_addr=0x100, memory latency 2, mem_rdata=0x00500093. Expect if_gnt and mem_req in cycle 0, mem_rvalid in cycle 2, if_rvalid=1 with if_rdata=0x00500093 in cycle 3, and the next grant no earlier than cycle 3.
2. Store: d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'b0011. Expect mem_we=1 and mem_be=0011 on the grant, then d_rvalid=1 with d_rdata=0 one cycle after the ack. No if_rvalid.
3. Starvation with STARVE_MAX=4, both requests held continuously. Expect grants in the order D, D, D, D, IF, D, ...; starve_cnt returns to 0 after the IF grant.
4. Flush: IF granted, flush pulsed in the next cycle, mem_rvalid arrives later. Expect no if_rvalid. A subsequent fetch to 0x200 returns normally.
5. Flush coincident with mem_rvalid for an IF transaction: no if_rvalid. Flush during a D load: d_rvalid is still produced with the correct data.
6. Reset mid-WAIT: assert rst for 1 cycle after a grant, then inject mem_rvalid. Expect all outputs 0 and no rvalid pulse, and a new request granted in the first cycle after reset deasserts.
